// File: rtl/lfsr_checker_if.sv
// Bundles the checker's serial-receive, status and snapshot signals.
// The master side drives the stimulus; the slave side is the checker.
interface lfsr_checker_if;
    logic        start;
    logic        in_valid;
    logic        in_bit;
    logic        fetch;
    logic        locked;
    logic        err_pulse;
    logic [15:0] err_count;
    logic [1:0]  state;
    logic [5:0]  snap;
    logic        write;

    modport master (
        output start, in_valid, in_bit, fetch,
        input  locked, err_pulse, err_count, state, snap, write
    );

    modport slave (
        input  start, in_valid, in_bit, fetch,
        output locked, err_pulse, err_count, state, snap, write
    );
endinterface

// File: rtl/lfsr_checker.sv
// Serial pattern checker for the 6-bit LFSR generator's out[6] stream.
// Self-seeds from the first six valid bits, then predicts each following
// bit, counting mismatches per window and overall (saturating).
module lfsr_checker #(
    parameter logic [5:0] TAPS      = 6'b100000,
    parameter int          WINDOW    = 16,
    parameter int          LOCK_ERRS = 4
) (
    input logic          clock,
    input logic          reset_n,
    lfsr_checker_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SEED  = 2'b01,
        ST_CHECK = 2'b10,
        ST_LOST  = 2'b11
    } state_e;

    localparam logic [7:0] WINDOW_C    = 8'(WINDOW);
    localparam logic [7:0] LOCK_ERRS_C = 8'(LOCK_ERRS);

    state_e      state_q,     state_d;
    logic [6:1]  local_q,     local_d;
    logic [2:0]  seed_cnt_q,  seed_cnt_d;
    logic [7:0]  win_cnt_q,   win_cnt_d;
    logic [7:0]  win_err_q,   win_err_d;
    logic        locked_q,    locked_d;
    logic        err_pulse_q, err_pulse_d;
    logic [15:0] err_count_q, err_count_d;
    logic [5:0]  snap_q,      snap_d;
    logic        write_q,     write_d;

    logic        fb;
    logic        mismatch;
    logic [7:0]  win_cnt_inc;
    logic [7:0]  win_err_inc;

    // Next-state: start wins over bit processing; seeding shifts in_bit in,
    // checking shifts the predicted feedback in and compares against local[6].
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
        state_d     = state_q;
        local_d     = local_q;
        seed_cnt_d  = seed_cnt_q;
        win_cnt_d   = win_cnt_q;
        win_err_d   = win_err_q;
        err_count_d = err_count_q;
        err_pulse_d = 1'b0;
        snap_d      = bus.fetch ? local_q : snap_q;
        write_d     = bus.fetch;
        fb          = ^(local_q & TAPS);
        mismatch    = bus.in_bit ^ local_q[6];
        win_cnt_inc = win_cnt_q + 8'd1;
        win_err_inc = win_err_q + {7'd0, mismatch};

        if (bus.start) begin
            state_d     = ST_SEED;
            local_d     = '0;
            seed_cnt_d  = '0;
            win_cnt_d   = '0;
            win_err_d   = '0;
            err_count_d = '0;
        end else if (bus.in_valid) begin
            unique case (state_q)
                ST_SEED: begin
                    local_d    = {local_q[5:1], bus.in_bit};
                    seed_cnt_d = seed_cnt_q + 3'd1;
                    if (seed_cnt_q == 3'd5) begin
                        state_d = ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    local_d     = {local_q[5:1], fb};
                    err_pulse_d = mismatch;
                    if (mismatch && (err_count_q != 16'hFFFF)) begin
                        err_count_d = err_count_q + 16'd1;
                    end
                    // Loss of lock outranks window expiry on the same bit.
                    if (win_err_inc == LOCK_ERRS_C) begin
                        state_d   = ST_LOST;
                        win_cnt_d = win_cnt_inc;
                        win_err_d = win_err_inc;
                    end else if (win_cnt_inc == WINDOW_C) begin
                        win_cnt_d = '0;
                        win_err_d = '0;
                    end else begin
                        win_cnt_d = win_cnt_inc;
                        win_err_d = win_err_inc;
                    end
                end
                default: ; // IDLE and LOST ignore incoming bits
            endcase
        end

        locked_d = (state_d == ST_CHECK);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        // NOTE: reset is sampled only on the clock edge, so it is a plain if inside the clocked block.
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            local_q     <= '0;
            seed_cnt_q  <= '0;
            win_cnt_q   <= '0;
            win_err_q   <= '0;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
            err_count_q <= '0;
            snap_q      <= '0;
            write_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so all registers update from pre-edge values.
            state_q     <= state_d;
            local_q     <= local_d;
            seed_cnt_q  <= seed_cnt_d;
            win_cnt_q   <= win_cnt_d;
            win_err_q   <= win_err_d;
            locked_q    <= locked_d;
            err_pulse_q <= err_pulse_d;
            err_count_q <= err_count_d;
            snap_q      <= snap_d;
            write_q     <= write_d;
        end
    end

    assign bus.locked    = locked_q;
    assign bus.err_pulse = err_pulse_q;
    assign bus.err_count = err_count_q;
    assign bus.state     = state_q;
    assign bus.snap      = snap_q;
    assign bus.write     = write_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// Directed bench for lfsr_checker: the generator stream is the period-6
// sequence 1,0,1,1,0,0; expected values are worked out by hand per step.
module tb_lfsr_checker;

    logic clk;
    logic reset_n;
    int   n_total;
    int   n_fail;
    int   pos;
    logic [0:5] pat_bits;
    logic [15:0] exp_cnt;

    lfsr_checker_if bus ();

    lfsr_checker #(
        .TAPS      (6'b100000),
        .WINDOW    (16),
        .LOCK_ERRS (4)
    ) dut (
        .clock   (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present one valid stream bit (optionally inverted) for one cycle.
    task automatic send_bit(input logic inv);
        bus.in_valid = 1'b1;
        bus.in_bit   = pat_bits[pos % 6] ^ inv;
        pos++;
        cycle();
        bus.in_valid = 1'b0;
        bus.in_bit   = 1'b0;
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        cycle();
        bus.start = 1'b0;
        pos       = 0;
    endtask

    task automatic seed6();
        for (int i = 0; i < 6; i++) begin
            send_bit(1'b0);
            if (i == 4) check("seed_not_yet", 16'(bus.state), 16'h1);
        end
        check("seed_state", 16'(bus.state), 16'h2);
        check("seed_locked", 16'(bus.locked), 16'h1);
    endtask

    initial begin
        n_total      = 0;
        n_fail       = 0;
        pos          = 0;
        pat_bits     = 6'b101100;
        reset_n      = 1'b0;
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_bit   = 1'b0;
        bus.fetch    = 1'b0;

        // Reset held 3 cycles while inputs toggle.
        for (int i = 0; i < 3; i++) begin
            bus.start    = ~i[0];
            bus.in_valid = i[0];
            bus.in_bit   = 1'b1;
            bus.fetch    = 1'b1;
            cycle();
        end
        check("rst_state", 16'(bus.state), 16'h0);
        check("rst_locked", 16'(bus.locked), 16'h0);
        check("rst_err_pulse", 16'(bus.err_pulse), 16'h0);
        check("rst_err_count", bus.err_count, 16'h0);
        check("rst_snap", 16'(bus.snap), 16'h0);
        check("rst_write", 16'(bus.write), 16'h0);

        // IDLE ignores valid bits.
        reset_n      = 1'b1;
        bus.start    = 1'b0;
        bus.fetch    = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_bit   = 1'b1;
        cycle();
        cycle();
        bus.in_valid = 1'b0;
        check("idle_state", 16'(bus.state), 16'h0);

        // Clean lock over 30 bits.
        do_start();
        check("start_state", 16'(bus.state), 16'h1);
        check("start_locked", 16'(bus.locked), 16'h0);
        seed6();
        for (int i = 0; i < 24; i++) begin
            send_bit(1'b0);
            check("clean_err_pulse", 16'(bus.err_pulse), 16'h0);
        end
        check("clean_err_count", bus.err_count, 16'h0);
        check("clean_state", 16'(bus.state), 16'h2);

        // Single error at valid bit 10, then errors spread across two windows.
        do_start();
        check("restart_count", bus.err_count, 16'h0);
        seed6();
        exp_cnt = 16'h0;
        for (int c = 0; c < 20; c++) begin
            logic inv;
            inv = (c == 3) || (c == 5) || (c == 7) || (c >= 16);
            send_bit(inv);
            if (inv) exp_cnt++;
            check("win_err_pulse", 16'(bus.err_pulse), 16'(inv));
            check("win_err_count", bus.err_count, exp_cnt);
            if (c == 3) check("single_locked", 16'(bus.locked), 16'h1);
            if (c == 18) check("window_cleared_locked", 16'(bus.locked), 16'h1);
        end
        check("window_lost_state", 16'(bus.state), 16'h3);
        check("window_lost_locked", 16'(bus.locked), 16'h0);
        check("window_lost_count", bus.err_count, 16'd7);

        // Burst of 4 errors inside one window.
        do_start();
        seed6();
        for (int c = 0; c < 10; c++) begin
            send_bit((c == 1) || (c == 2) || (c == 8) || (c == 9));
            if (c == 8) check("burst_pre_state", 16'(bus.state), 16'h2);
        end
        check("burst_state", 16'(bus.state), 16'h3);
        check("burst_locked", 16'(bus.locked), 16'h0);
        check("burst_count", bus.err_count, 16'd4);
        check("burst_pulse", 16'(bus.err_pulse), 16'h1);
        for (int c = 0; c < 6; c++) begin
            send_bit(c[0]);
            check("lost_pulse", 16'(bus.err_pulse), 16'h0);
        end
        check("lost_count_hold", bus.err_count, 16'd4);
        check("lost_state_hold", 16'(bus.state), 16'h3);
        do_start();
        check("relock_count_clr", bus.err_count, 16'h0);
        check("relock_seed_state", 16'(bus.state), 16'h1);
        seed6();
        check("relock_count", bus.err_count, 16'h0);

        // Gapped stream: in_valid low every other cycle.
        do_start();
        for (int i = 0; i < 6; i++) begin
            send_bit(1'b0);
            cycle();
            if (i == 4) check("gap_seed_not_yet", 16'(bus.state), 16'h1);
        end
        check("gap_locked", 16'(bus.locked), 16'h1);
        for (int i = 0; i < 6; i++) begin
            send_bit(1'b0);
            cycle();
        end
        check("gap_err_count", bus.err_count, 16'h0);
        check("gap_state", 16'(bus.state), 16'h2);

        // start collides with a valid bit: that bit is dropped.
        bus.start    = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_bit   = 1'b0;
        cycle();
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        pos          = 0;
        check("coll_state", 16'(bus.state), 16'h1);
        seed6();
        for (int i = 0; i < 6; i++) send_bit(1'b0);
        check("coll_err_count", bus.err_count, 16'h0);

        // Snapshot after two check bits: local 101100 -> 011001 -> 110010.
        do_start();
        seed6();
        send_bit(1'b0);
        send_bit(1'b0);
        bus.fetch = 1'b1;
        cycle();
        bus.fetch = 1'b0;
        check("snap_write", 16'(bus.write), 16'h1);
        check("snap_value", 16'(bus.snap), 16'h32);
        cycle();
        check("snap_write_drop", 16'(bus.write), 16'h0);
        check("snap_hold", 16'(bus.snap), 16'h32);

        // Mid-CHECK reset after one error.
        send_bit(1'b1);
        check("pre_rst_count", bus.err_count, 16'h1);
        reset_n      = 1'b0;
        bus.fetch    = 1'b1;
        bus.start    = 1'b1;
        bus.in_valid = 1'b1;
        cycle();
        check("mid_rst_state", 16'(bus.state), 16'h0);
        check("mid_rst_locked", 16'(bus.locked), 16'h0);
        check("mid_rst_err_pulse", 16'(bus.err_pulse), 16'h0);
        check("mid_rst_err_count", bus.err_count, 16'h0);
        check("mid_rst_snap", 16'(bus.snap), 16'h0);
        check("mid_rst_write", 16'(bus.write), 16'h0);

        $display("%0d/%0d checks passed", n_total - n_fail, n_total);
        $finish;
    end

endmodule
